rotate_vidin_burst_writer: RTL and testbench

//  Parametrised successor to the rotating scandoubler's input stage: captures incoming video,

---
 rtl/rotate_vidin_burst_writer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_rotate_vidin_burst_writer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_vidin_burst_writer.sv
// Video input stage: packs incoming pixels to RGB565, groups them into fixed-length SDRAM
// write bursts with per-burst frame/row/column descriptors, and rotates 2 or 3 frame buffers.
module rotate_vidin_burst_writer #(
    parameter int COLOR_DEPTH = 6,
    parameter int HCNT_WIDTH  = 10,
    parameter int BURST_LEN   = 16,
    parameter int FIFO_BURSTS = 2,
    parameter int NUM_FRAMES  = 3
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   pe_in,
    input  logic                   hb_in,
    input  logic                   vb_in,
    input  logic [COLOR_DEPTH-1:0] r_in,
    input  logic [COLOR_DEPTH-1:0] g_in,
    input  logic [COLOR_DEPTH-1:0] b_in,
    input  logic                   flip_x,
    input  logic                   flip_y,
    input  logic [1:0]             rd_frame,
    output logic                   vidin_req,
    output logic [1:0]             vidin_frame,
    output logic [HCNT_WIDTH-1:0]  vidin_row,
    output logic [HCNT_WIDTH-1:0]  vidin_col,
    output logic [15:0]            vidin_d,
    input  logic                   vidin_ack,
    output logic [1:0]             last_frame,
    output logic [HCNT_WIDTH-1:0]  xsize,
    output logic [HCNT_WIDTH-1:0]  ysize,
    output logic                   overflow,
    output logic [7:0]             drop_count
);
    localparam int IW    = $clog2(BURST_LEN);
    localparam int SW    = $clog2(FIFO_BURSTS);
    localparam int DEPTH = FIFO_BURSTS * BURST_LEN;
    localparam int NREP  = (6 + COLOR_DEPTH - 1) / COLOR_DEPTH;
    localparam int RW    = NREP * COLOR_DEPTH;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                state_q, state_d;
    logic                  hb_q, vb_q;
    logic [HCNT_WIDTH-1:0] xpos_q, xpos_d, ypos_q, ypos_d, line_w_q, line_w_d;
    logic [HCNT_WIDTH-1:0] xsize_q, xsize_d, ysize_q, ysize_d;
    logic                  flip_x_q, flip_x_d, flip_y_q, flip_y_d;
    logic [1:0]            wr_frame_q, wr_frame_d, last_frame_q, last_frame_d;
    logic [SW-1:0]         wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
    logic [IW:0]           fill_q, fill_d;
    logic [SW:0]           closed_q, closed_d;
    logic [IW-1:0]         word_q, word_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_q, drop_d;

    logic [15:0]           mem_q  [DEPTH];
    logic [15:0]           mem_d  [DEPTH];
    logic [1:0]            dfrm_q [FIFO_BURSTS];
    logic [1:0]            dfrm_d [FIFO_BURSTS];
    logic [HCNT_WIDTH-1:0] drow_q [FIFO_BURSTS];
    logic [HCNT_WIDTH-1:0] drow_d [FIFO_BURSTS];
    logic [HCNT_WIDTH-1:0] dcol_q [FIFO_BURSTS];
    logic [HCNT_WIDTH-1:0] dcol_d [FIFO_BURSTS];
    logic                  dfx_q  [FIFO_BURSTS];
    logic                  dfx_d  [FIFO_BURSTS];
    logic [IW:0]           dn_q   [FIFO_BURSTS];
    logic [IW:0]           dn_d   [FIFO_BURSTS];

    logic                  hb_rise, vb_rise, capture, full, wr_en, close, free;
    logic [HCNT_WIDTH-1:0] cur_row, cur_col;
    logic [1:0]            nf1, nf2, next_frame;
    logic [RW-1:0]         r_rep, g_rep, b_rep;
    logic [15:0]           pix;
    logic                  unused_rep_bits;

    // Replicating the channel and taking the top bits both truncates and MSB-extends.
    assign r_rep = {NREP{r_in}};
    assign g_rep = {NREP{g_in}};
    assign b_rep = {NREP{b_in}};
    assign pix   = {r_rep[RW-1 -: 5], g_rep[RW-1 -: 6], b_rep[RW-1 -: 5]};
    assign unused_rep_bits = ^{r_rep, g_rep, b_rep};

    assign hb_rise = hb_in & ~hb_q;
    assign vb_rise = vb_in & ~vb_q;
    assign capture = pe_in & ~hb_in & ~vb_in;
    assign full    = (closed_q == (SW+1)'(FIFO_BURSTS));
    assign wr_en   = capture & ~full;
    assign cur_row = flip_y_q ? (ysize_q - ypos_q - 1'b1) : ypos_q;
    assign cur_col = flip_x_q ? (xsize_q - xpos_q - 1'b1) : xpos_q;

    always_comb begin
        nf1 = (wr_frame_q == 2'd2) ? 2'd0 : wr_frame_q + 2'd1;
        nf2 = (nf1 == 2'd2) ? 2'd0 : nf1 + 2'd1;
        if (NUM_FRAMES == 2) next_frame = {1'b0, ~wr_frame_q[0]};
        else                 next_frame = (nf1 == rd_frame) ? nf2 : nf1;
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        rd_slot_d    = rd_slot_q;
        free         = 1'b0;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        line_w_d     = line_w_q;
        xsize_d      = xsize_q;
        ysize_d      = ysize_q;
        flip_x_d     = flip_x_q;
        flip_y_d     = flip_y_q;
        wr_frame_d   = wr_frame_q;
        last_frame_d = last_frame_q;
        wr_slot_d    = wr_slot_q;
        fill_d       = fill_q;
        closed_d     = closed_q;
        overflow_d   = capture & full;
        drop_d       = drop_q;
        close        = 1'b0;
        mem_d        = mem_q;
        dfrm_d       = dfrm_q;
        drow_d       = drow_q;
        dcol_d       = dcol_q;
        dfx_d        = dfx_q;
        dn_d         = dn_q;

        case (state_q)
            S_IDLE: begin
                word_d = '0;
                if (closed_q != '0) state_d = S_BURST;
            end
            S_BURST: begin
                if (vidin_ack) begin
                    if (word_q == IW'(BURST_LEN - 1)) begin
                        word_d    = '0;
                        state_d   = S_IDLE;
                        free      = 1'b1;
                        rd_slot_d = rd_slot_q + 1'b1;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (vb_in) begin
            xpos_d = '0;
            ypos_d = '0;
        end else if (hb_rise) begin
            xpos_d   = '0;
            ypos_d   = ypos_q + 1'b1;
            line_w_d = xpos_q;
        end else if (capture) begin
            xpos_d = xpos_q + 1'b1;
        end

        if (capture & full & (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

        if (vb_rise) begin
            ysize_d      = ypos_q;
            xsize_d      = line_w_q;
            last_frame_d = wr_frame_q;
            wr_frame_d   = next_frame;
            flip_x_d     = flip_x;
            flip_y_d     = flip_y;
            drop_d       = '0;
        end

        // Descriptor captures the first word's address; later words derive from it.
        if (wr_en) begin
            mem_d[{wr_slot_q, fill_q[IW-1:0]}] = pix;
            if (fill_q == '0) begin
                dfrm_d[wr_slot_q] = wr_frame_q;
                drow_d[wr_slot_q] = cur_row;
                dcol_d[wr_slot_q] = cur_col;
                dfx_d[wr_slot_q]  = flip_x_q;
            end
            fill_d = fill_q + 1'b1;
            if (fill_q == (IW+1)'(BURST_LEN - 1)) close = 1'b1;
        end else if ((hb_rise | vb_rise) && (fill_q != '0)) begin
            close = 1'b1;
        end

        if (close) begin
            dn_d[wr_slot_q] = wr_en ? fill_q + 1'b1 : fill_q;
            wr_slot_d       = wr_slot_q + 1'b1;
            fill_d          = '0;
        end

        case ({close, free})
            2'b10:   closed_d = closed_q + 1'b1;
            2'b01:   closed_d = closed_q - 1'b1;
            default: closed_d = closed_q;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hb_q         <= 1'b0;
            vb_q         <= 1'b0;
            xpos_q       <= '0;
            ypos_q       <= '0;
            line_w_q     <= '0;
            xsize_q      <= HCNT_WIDTH'(320);
            ysize_q      <= HCNT_WIDTH'(240);
            flip_x_q     <= 1'b0;
            flip_y_q     <= 1'b0;
            wr_frame_q   <= 2'd0;
            last_frame_q <= 2'(NUM_FRAMES - 1);
            wr_slot_q    <= '0;
            rd_slot_q    <= '0;
            fill_q       <= '0;
            closed_q     <= '0;
            word_q       <= '0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int i = 0; i < FIFO_BURSTS; i++) begin
                dfrm_q[i] <= '0;
                drow_q[i] <= '0;
                dcol_q[i] <= '0;
                dfx_q[i]  <= 1'b0;
                dn_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            hb_q         <= hb_in;
            vb_q         <= vb_in;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            line_w_q     <= line_w_d;
            xsize_q      <= xsize_d;
            ysize_q      <= ysize_d;
            flip_x_q     <= flip_x_d;
            flip_y_q     <= flip_y_d;
            wr_frame_q   <= wr_frame_d;
            last_frame_q <= last_frame_d;
            wr_slot_q    <= wr_slot_d;
            rd_slot_q    <= rd_slot_d;
            fill_q       <= fill_d;
            closed_q     <= closed_d;
            word_q       <= word_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
            mem_q        <= mem_d;
            dfrm_q       <= dfrm_d;
            drow_q       <= drow_d;
            dcol_q       <= dcol_d;
            dfx_q        <= dfx_d;
            dn_q         <= dn_d;
        end
    end

    // Words past the captured count of a short burst read back as zero padding.
    assign vidin_req   = (state_q == S_BURST);
    assign vidin_frame = dfrm_q[rd_slot_q];
    assign vidin_row   = drow_q[rd_slot_q];
    assign vidin_col   = dfx_q[rd_slot_q] ? dcol_q[rd_slot_q] - HCNT_WIDTH'(word_q)
                                          : dcol_q[rd_slot_q] + HCNT_WIDTH'(word_q);
    assign vidin_d     = ((state_q == S_BURST) && ({1'b0, word_q} < dn_q[rd_slot_q]))
                         ? mem_q[{rd_slot_q, word_q}] : 16'h0000;
    assign last_frame  = last_frame_q;
    assign xsize       = xsize_q;
    assign ysize       = ysize_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_rotate_vidin_burst_writer.sv
// Self-checking bench for rotate_vidin_burst_writer: a reference model pushes expected burst
// words as pixels are driven; a monitor pops and compares each word the controller consumes.
module tb_rotate_vidin_burst_writer;
    localparam int CD = 6;
    localparam int HW = 10;
    localparam int BL = 16;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          pe_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0;
    logic [CD-1:0] r_in = '0, g_in = '0, b_in = '0;
    logic          flip_x = 1'b0, flip_y = 1'b0;
    logic [1:0]    rd_frame = 2'd1;
    logic          vidin_ack = 1'b0;
    logic          vidin_req;
    logic [1:0]    vidin_frame, last_frame;
    logic [HW-1:0] vidin_row, vidin_col, xsize, ysize;
    logic [15:0]   vidin_d;
    logic          overflow;
    logic [7:0]    drop_count;

    rotate_vidin_burst_writer #(
        .COLOR_DEPTH(CD), .HCNT_WIDTH(HW), .BURST_LEN(BL), .FIFO_BURSTS(2), .NUM_FRAMES(3)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .pe_in(pe_in), .hb_in(hb_in), .vb_in(vb_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .flip_x(flip_x), .flip_y(flip_y),
        .rd_frame(rd_frame), .vidin_req(vidin_req), .vidin_frame(vidin_frame),
        .vidin_row(vidin_row), .vidin_col(vidin_col), .vidin_d(vidin_d),
        .vidin_ack(vidin_ack), .last_frame(last_frame), .xsize(xsize), .ysize(ysize),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [1:0]    frame;
        logic [HW-1:0] row;
        logic [HW-1:0] col;
        logic [15:0]   d;
    } word_t;

    word_t      exp_q[$];
    word_t      mon_w, mon_a;
    int         n_checks = 0, n_fail = 0, bursts_seen = 0, ovf_seen = 0;
    logic       req_prev = 1'b0;

    logic [HW-1:0] m_xsize = 10'd320, m_ysize = 10'd240, m_linew = '0;
    int            m_xpos = 0, m_ypos = 0, m_fill = 0;
    logic          m_fx = 1'b0, m_fy = 1'b0;
    logic [1:0]    m_frame = 2'd0, m_last = 2'd2;

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (vidin_req && !req_prev) bursts_seen++;
            if (overflow) ovf_seen++;
            if (vidin_req && vidin_ack) begin
                mon_a = {vidin_frame, vidin_row, vidin_col, vidin_d};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected got frame=%0d row=%0d col=%0d d=%h exp none",
                             vidin_frame, vidin_row, vidin_col, vidin_d);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (mon_a !== mon_w) begin
                        n_fail++;
                        $display("FAIL sb_word got frame=%0d row=%0d col=%0d d=%h exp frame=%0d row=%0d col=%0d d=%h",
                                 mon_a.frame, mon_a.row, mon_a.col, mon_a.d,
                                 mon_w.frame, mon_w.row, mon_w.col, mon_w.d);
                    end
                end
            end
        end
        req_prev = vidin_req;
    end

    task automatic push_word(input logic [15:0] d, input int pos);
        word_t         w;
        logic [HW-1:0] p, y;
        p       = pos[HW-1:0];
        y       = m_ypos[HW-1:0];
        w.frame = m_frame;
        w.row   = m_fy ? (m_ysize - 10'd1 - y) : y;
        w.col   = m_fx ? (m_xsize - 10'd1 - p) : p;
        w.d     = d;
        exp_q.push_back(w);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_xsize = 10'd320; m_ysize = 10'd240; m_linew = '0;
        m_xpos = 0; m_ypos = 0; m_fill = 0;
        m_fx = 1'b0; m_fy = 1'b0; m_frame = 2'd0; m_last = 2'd2;
    endtask

    task automatic drive_pixel(input logic store);
        logic [5:0] r, g, b;
        r = 6'($urandom_range(0, 63));
        g = 6'($urandom_range(0, 63));
        b = 6'($urandom_range(0, 63));
        @(posedge clk_sys); #1;
        pe_in = 1'b1; r_in = r; g_in = g; b_in = b;
        if (store) begin
            push_word({r[5:1], g, b[5:1]}, m_xpos);
            m_fill = (m_fill + 1) % BL;
        end
        m_xpos++;
        @(posedge clk_sys); #1;
        pe_in = 1'b0;
    endtask

    task automatic do_hblank();
        if (m_fill != 0) begin
            for (int i = 0; i < BL - m_fill; i++) push_word(16'h0000, m_xpos + i);
            m_fill = 0;
        end
        m_linew = m_xpos[HW-1:0];
        m_xpos  = 0;
        m_ypos++;
        @(posedge clk_sys); #1 hb_in = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1 hb_in = 1'b0;
    endtask

    task automatic drive_line(input int n);
        for (int i = 0; i < n; i++) drive_pixel(1'b1);
        do_hblank();
    endtask

    task automatic do_vblank();
        logic [1:0] c;
        m_ysize = m_ypos[HW-1:0];
        m_xsize = m_linew;
        m_last  = m_frame;
        c = (m_frame == 2'd2) ? 2'd0 : m_frame + 2'd1;
        if (c == rd_frame) c = (c == 2'd2) ? 2'd0 : c + 2'd1;
        m_frame = c;
        m_fx = flip_x; m_fy = flip_y;
        m_ypos = 0;
        @(posedge clk_sys); #1 vb_in = 1'b1;
        repeat (6) @(posedge clk_sys);
        #1 vb_in = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk_sys);
            n++;
        end
        repeat (3) @(posedge clk_sys);
        #1;
        n_checks++;
        if (exp_q.size() != 0 || vidin_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain got left=%0d req=%b exp left=0 req=0", name, exp_q.size(), vidin_req);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (vidin_req !== 1'b1 && n < 200) begin
            @(posedge clk_sys); #1;
            n++;
        end
        n_checks++;
        if (vidin_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_req_timeout got req=%b exp 1", name, vidin_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        n_checks++;
        if (vidin_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", vidin_req); end
        n_checks++;
        if ({vidin_frame, vidin_row, vidin_col, vidin_d} !== '0) begin
            n_fail++;
            $display("FAIL reset_word got frame=%0d row=%0d col=%0d d=%h exp all 0", vidin_frame, vidin_row, vidin_col, vidin_d);
        end
        n_checks++;
        if (last_frame !== 2'd2) begin n_fail++; $display("FAIL reset_last_frame got=%0d exp=2", last_frame); end
        n_checks++;
        if (xsize !== 10'd320 || ysize !== 10'd240) begin
            n_fail++;
            $display("FAIL reset_size got=%0dx%0d exp=320x240", xsize, ysize);
        end
        n_checks++;
        if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_drop got ovf=%b cnt=%0d exp ovf=0 cnt=0", overflow, drop_count);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_full_lines();
        int b0;
        vidin_ack = 1'b1;
        rd_frame  = 2'd1;
        b0 = bursts_seen;
        repeat (4) drive_line(320);
        wait_drain("full");
        n_checks++;
        if (bursts_seen - b0 != 80) begin
            n_fail++;
            $display("FAIL full_bursts got=%0d exp=80", bursts_seen - b0);
        end
        do_vblank();
        n_checks++;
        if (xsize !== 10'd320 || ysize !== 10'd4) begin
            n_fail++;
            $display("FAIL full_size got=%0dx%0d exp=320x4", xsize, ysize);
        end
        n_checks++;
        if (last_frame !== 2'd0) begin n_fail++; $display("FAIL frame_rotate_last got=%0d exp=0", last_frame); end
    endtask

    task automatic test_partial_and_tall();
        int b0;
        b0 = bursts_seen;
        drive_line(300);
        wait_drain("partial");
        n_checks++;
        if (bursts_seen - b0 != 19) begin
            n_fail++;
            $display("FAIL partial_bursts got=%0d exp=19", bursts_seen - b0);
        end
        repeat (238) drive_line(16);
        drive_line(320);
        wait_drain("tall");
        flip_x = 1'b1;
        flip_y = 1'b1;
        do_vblank();
        n_checks++;
        if (xsize !== 10'd320 || ysize !== 10'd240) begin
            n_fail++;
            $display("FAIL tall_size got=%0dx%0d exp=320x240", xsize, ysize);
        end
        n_checks++;
        if (last_frame !== m_last) begin n_fail++; $display("FAIL tall_last_frame got=%0d exp=%0d", last_frame, m_last); end
    endtask

    task automatic test_flip();
        vidin_ack = 1'b0;
        drive_line(20);
        wait_req("flip");
        n_checks++;
        if (vidin_row !== 10'd239 || vidin_col !== 10'd319) begin
            n_fail++;
            $display("FAIL flip_addr got row=%0d col=%0d exp row=239 col=319", vidin_row, vidin_col);
        end
        vidin_ack = 1'b1;
        wait_drain("flip");
        flip_x = 1'b0;
        flip_y = 1'b0;
        do_vblank();
    endtask

    task automatic test_overflow();
        int o0;
        vidin_ack = 1'b0;
        o0 = ovf_seen;
        for (int i = 0; i < 48; i++) drive_pixel(i < 32);
        repeat (2) @(posedge clk_sys);
        #1;
        n_checks++;
        if (ovf_seen - o0 != 16) begin n_fail++; $display("FAIL ovf_pulses got=%0d exp=16", ovf_seen - o0); end
        n_checks++;
        if (drop_count !== 8'd16) begin n_fail++; $display("FAIL ovf_drop_count got=%0d exp=16", drop_count); end
        vidin_ack = 1'b1;
        do_hblank();
        wait_drain("ovf");
        do_vblank();
        n_checks++;
        if (drop_count !== 8'd0) begin n_fail++; $display("FAIL ovf_drop_clear got=%0d exp=0", drop_count); end
    endtask

    task automatic test_reset_mid_burst();
        vidin_ack = 1'b0;
        for (int i = 0; i < 16; i++) drive_pixel(1'b1);
        wait_req("mid");
        vidin_ack = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1 vidin_ack = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (vidin_req !== 1'b0) begin n_fail++; $display("FAIL mid_reset_req got=%b exp=0", vidin_req); end
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
        for (int i = 0; i < 16; i++) drive_pixel(1'b1);
        wait_req("restart");
        n_checks++;
        if (vidin_col !== 10'd0 || vidin_frame !== 2'd0 || vidin_d !== exp_q[0].d) begin
            n_fail++;
            $display("FAIL restart_word0 got col=%0d frame=%0d d=%h exp col=0 frame=0 d=%h",
                     vidin_col, vidin_frame, vidin_d, exp_q[0].d);
        end
        vidin_ack = 1'b1;
        do_hblank();
        wait_drain("restart");
    endtask

    initial begin
        #3ms;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_lines();
        test_partial_and_tall();
        test_flip();
        test_overflow();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
